// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit seven-segment scan driver:
// active-low hex glyph table, blank code and default scan divider.
package seg7_pkg;

   localparam int CLK_DIV_DEFAULT = 100000;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Segment order {g,f,e,d,c,b,a}, active-low; entry n is the glyph for hex digit n.
   localparam logic [15:0][6:0] GLYPH_TBL = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Purely combinational 4-bit hex to active-low seven-segment decode.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = GLYPH_TBL[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed seven-segment driver: a free-running divider alternates
// the anodes, and both digits come from one snapshot taken at each frame start.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       enable,
   input  logic [7:0] value,
   input  logic [1:0] dp_in,
   input  logic       blank_lz,
   output logic [1:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame
);

   localparam int             DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             sel_q, sel_d;
   logic [7:0]       snap_q, snap_d;
   logic             frame_q, frame_d;
   logic             tick;

   logic [3:0]       digit;
   logic [6:0]       glyph;
   logic             blank_now;

   always_comb begin
      div_d   = div_q;
      sel_d   = sel_q;
      snap_d  = snap_q;
      frame_d = 1'b0;
      tick    = enable && (div_q == DIV_LAST);
      if (enable) begin
         div_d = tick ? '0 : div_q + DIV_W'(1);
      end
      if (tick) begin
         sel_d = ~sel_q;
         // Leaving digit1 closes a frame: capture both digits together.
         if (sel_q) begin
            snap_d  = value;
            frame_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         div_q   <= '0;
         sel_q   <= 1'b0;
         snap_q  <= 8'h00;
         frame_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         sel_q   <= sel_d;
         snap_q  <= snap_d;
         frame_q <= frame_d;
      end
   end

   assign digit = sel_q ? snap_q[7:4] : snap_q[3:0];

   hex_to_seg7 u_dec (
      .hex (digit),
      .seg (glyph)
   );

   // Leading-zero blanking applies only to the upper digit.
   assign blank_now = sel_q && blank_lz && (snap_q[7:4] == 4'h0);

   assign an    = sel_q ? 2'b01 : 2'b10;
   assign seg   = blank_now ? SEG_BLANK : glyph;
   assign dp    = ~dp_in[sel_q];
   assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with CLK_DIV = 4: a reference model
// predicts every cycle's outputs into a queue, a monitor pops and compares.
module tb_seg7_scan_driver;

   localparam int CD = 4;

   logic       clk;
   logic       clr;
   logic       enable;
   logic [7:0] value;
   logic [1:0] dp_in;
   logic       blank_lz;
   logic [1:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame;

   typedef struct packed {
      logic [1:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       frame;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   bit done  = 0;

   logic [6:0] glyph_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan_driver #(.CLK_DIV(CD)) dut (
      .clk      (clk),
      .clr      (clr),
      .enable   (enable),
      .value    (value),
      .dp_in    (dp_in),
      .blank_lz (blank_lz),
      .an       (an),
      .seg      (seg),
      .dp       (dp),
      .frame    (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: position within a 2*CD frame counts enabled cycles since
   // reset; the first half shows digit0, the second half digit1.
   initial begin
      int   pos;
      logic [7:0] snap;
      bit   fr;
      logic s_clr, s_en;
      logic [7:0] s_val;
      int   sel;
      logic [3:0] nib;
      exp_t e;
      pos  = 0;
      snap = 8'h00;
      fr   = 0;
      forever begin
         @(posedge clk);
         s_clr = clr;
         s_en  = enable;
         s_val = value;
         fr    = 0;
         if (s_clr) begin
            pos  = 0;
            snap = 8'h00;
         end else if (s_en) begin
            pos = (pos + 1) % (2 * CD);
            if (pos == 0) begin
               snap = s_val;
               fr   = 1;
            end
         end
         #2;
         sel = pos / CD;
         nib = (sel == 1) ? snap[7:4] : snap[3:0];
         e.an    = (sel == 1) ? 2'b01 : 2'b10;
         e.seg   = (sel == 1 && blank_lz && snap[7:4] == 4'h0) ? 7'h7F : glyph_ref[nib];
         e.dp    = ~dp_in[sel];
         e.frame = fr;
         exp_q.push_back(e);
      end
   end

   // Monitor: compare each predicted cycle against the DUT at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!done && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (an !== e.an) begin
               n_bad++;
               $display("FAIL an @%0t: got %b want %b", $time, an, e.an);
            end
            n_cmp++;
            if (seg !== e.seg) begin
               n_bad++;
               $display("FAIL seg @%0t: got %b want %b (an=%b)", $time, seg, e.seg, an);
            end
            n_cmp++;
            if (dp !== e.dp) begin
               n_bad++;
               $display("FAIL dp @%0t: got %b want %b", $time, dp, e.dp);
            end
            n_cmp++;
            if (frame !== e.frame) begin
               n_bad++;
               $display("FAIL frame @%0t: got %b want %b", $time, frame, e.frame);
            end
            n_cmp++;
            if (!(an == 2'b01 || an == 2'b10)) begin
               n_bad++;
               $display("FAIL an_onehot @%0t: got %b want exactly one low bit", $time, an);
            end
         end
      end
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      clr      = 1'b1;
      enable   = 1'b1;
      value    = 8'h37;
      dp_in    = 2'b00;
      blank_lz = 1'b0;

      // Reset, then first frame capture of 0x37.
      cycles(2);
      clr = 1'b0;
      cycles(24);

      // Coherence: change value while digit1 is on screen.
      value = 8'h19;
      cycles(14);
      value = 8'h20;
      cycles(24);

      // Leading-zero blanking on and off.
      value    = 8'h05;
      blank_lz = 1'b1;
      cycles(20);
      blank_lz = 1'b0;
      cycles(12);

      // Hold with enable low, then reset and enable together mid-frame.
      value  = 8'hA6;
      enable = 1'b0;
      cycles(20);
      enable = 1'b1;
      cycles(3);
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      cycles(20);

      // Full glyph sweep with the digit1 decimal point requested.
      dp_in = 2'b10;
      for (int v = 0; v < 256; v++) begin
         value = 8'(v);
         cycles(2 * CD);
      end

      // Randomized traffic including enable gaps and occasional resets.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 15) == 0) value = 8'($urandom);
         dp_in    = 2'($urandom);
         blank_lz = 1'($urandom);
         enable   = ($urandom_range(0, 5) != 0);
         clr      = ($urandom_range(0, 199) == 0);
         cycles(1);
      end
      clr    = 1'b0;
      enable = 1'b1;
      cycles(4);

      @(negedge clk);
      #1;
      done = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
